// File: rtl/status_led_pkg.sv
// Shared mode encoding for the status LED controller.
package status_led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_STATIC = 2'd3
    } mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running step divider: counts 0..TICK_DIV-1 and flags the last count.
// tick is combinational from the count register and is masked by hold/clear.
module led_prescaler #(
    parameter int unsigned TICK_DIV = 6000000,
    parameter int unsigned DIV_W    = 32
) (
    input  logic clock,
    input  logic nReset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_count;

    // Divider counter; clear wins over hold, hold freezes the count.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!hold) begin
            if (r_count == LAST) r_count <= '0;
            else                 r_count <= r_count + DIV_W'(1);
        end
    end

    assign tick = !hold && !clear && (r_count == LAST);

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-mode status LED driver: rotate, bounce, blink or static host pattern,
// stepped by a prescaler tick.
// Optional activity LED pulse stretcher enabled by defining STATUS_LED_ACTIVITY_EN.
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 8,
    parameter int unsigned TICK_DIV    = 6000000,
    parameter int unsigned DIV_W       = 32
`ifdef STATUS_LED_ACTIVITY_EN
    ,
    parameter int unsigned ACT_STRETCH = 1000000
`endif
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic [1:0]          mode,
    input  logic                pause,
    input  logic [NUM_LEDS-1:0] pattern,
    output logic [NUM_LEDS-1:0] leds
`ifdef STATUS_LED_ACTIVITY_EN
    ,
    input  logic                act_in,
    output logic                act_led
`endif
);

    localparam int unsigned     POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    logic [NUM_LEDS-1:0] r_leds;
    logic [POS_W-1:0]    r_pos;
    logic                r_dir_up;
    mode_e               r_mode;

    mode_e               w_mode_in;
    logic                w_mode_chg;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_init;
    logic [NUM_LEDS-1:0] w_rot;
    logic [POS_W-1:0]    w_pos_nxt;
    logic                w_dir_nxt;

    led_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_step_div (
        .clock  (clock),
        .nReset (nReset),
        .clear  (w_mode_chg),
        .hold   (pause),
        .tick   (w_tick)
    );

    // Mode-change detect, initial images and next rotate/bounce values.
    always_comb begin
        w_mode_in  = mode_e'(mode);
        w_mode_chg = (w_mode_in != r_mode);
        w_rot      = (r_leds << 1) | (r_leds >> (NUM_LEDS - 1));
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir_up;

        case (w_mode_in)
            MODE_ROTATE: w_init = NUM_LEDS'(1);
            MODE_BOUNCE: w_init = NUM_LEDS'(1);
            MODE_BLINK:  w_init = '1;
            default:     w_init = pattern;
        endcase

        if (NUM_LEDS == 1) begin
            w_pos_nxt = '0;
        end else if (r_dir_up) begin
            if (r_pos == LAST_POS) begin
                w_dir_nxt = 1'b0;
                w_pos_nxt = r_pos - POS_W'(1);
            end else begin
                w_pos_nxt = r_pos + POS_W'(1);
            end
        end else begin
            if (r_pos == '0) begin
                w_dir_nxt = 1'b1;
                w_pos_nxt = POS_W'(1);
            end else begin
                w_pos_nxt = r_pos - POS_W'(1);
            end
        end
    end

    // Pattern engine: mode change reloads, otherwise step on tick unless paused.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_leds   <= NUM_LEDS'(1);
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_mode   <= MODE_ROTATE;
        end else if (w_mode_chg) begin
            r_mode   <= w_mode_in;
            r_leds   <= w_init;
            r_pos    <= '0;
            r_dir_up <= 1'b1;
        end else if (!pause) begin
            case (r_mode)
                MODE_ROTATE: if (w_tick) r_leds <= w_rot;
                MODE_BOUNCE: if (w_tick) begin
                    r_pos    <= w_pos_nxt;
                    r_dir_up <= w_dir_nxt;
                    r_leds   <= NUM_LEDS'(1) << w_pos_nxt;
                end
                MODE_BLINK:  if (w_tick) r_leds <= ~r_leds;
                default:     r_leds <= pattern;
            endcase
        end
    end

    assign leds = r_leds;

`ifdef STATUS_LED_ACTIVITY_EN
    localparam int unsigned ACT_W = $clog2(ACT_STRETCH + 1);

    logic [ACT_W-1:0] r_act_cnt;
    logic             r_act;

    // Activity stretcher: each act_in reloads; LED stays lit ACT_STRETCH cycles.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_act_cnt <= '0;
            r_act     <= 1'b0;
        end else if (act_in) begin
            r_act_cnt <= ACT_W'(ACT_STRETCH);
            r_act     <= 1'b1;
        end else begin
            if (r_act_cnt != '0) r_act_cnt <= r_act_cnt - ACT_W'(1);
            r_act <= (r_act_cnt > ACT_W'(1));
        end
    end

    assign act_led = r_act;
`endif

endmodule
